// File: rtl/sff_chain_pkg.sv
// Shared definitions for the serial scan-chain configuration loader.
package sff_chain_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Width of the shift-position counter for a chain of the given length.
    // The counter only has to reach width-1, so $clog2 is enough; the floor
    // of 1 keeps the counter declarable for the smallest legal chain.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sff_chain_loader_if.sv
// Bundle of the word handshake and serial chain signals of the loader.
// The master side is the config master together with the flop chain;
// the slave side is the loader itself.
interface sff_chain_loader_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             stall;
    logic             so;
    logic             sen;
    logic             si;
    logic             upd;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        output stall,
        input  so,
        input  sen,
        output si,
        input  upd,
        input  dout,
        input  dout_valid,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        input  stall,
        output so,
        output sen,
        input  si,
        output upd,
        output dout,
        output dout_valid,
        output busy
    );

endinterface

// File: rtl/sff_chain_sreg.sv
// Parallel-load, right-shift register with serial input at the MSB end.
// Used both for the outgoing word (bit 0 leaves first) and for capturing
// the old chain contents arriving from the chain tail.
module sff_chain_sreg #(
    parameter int WIDTH = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    // Reset beats load, load beats shift; each shift moves toward bit 0
    always_ff @(posedge ck) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {ser_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sff_chain_loader.sv
// Serial configuration loader: takes a word over valid/ready, shifts it
// LSB-first into an external flop chain while capturing the chain's old
// contents from its tail, then strobes update for one cycle.
module sff_chain_loader
    import sff_chain_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic               ck,
    input logic               rst,
    sff_chain_loader_if.slave bus
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] dout_q;
    logic             accept;
    logic             advance;

    // A word is taken only in IDLE and never while reset is asserted, so a
    // simultaneous reset wins over the handshake.
    assign accept  = (state == IDLE) && bus.din_valid && !rst;

    // The chain moves exactly when the loader shifts its own registers, so
    // si is sampled on the same edge that pushes the tail value out.
    assign advance = (state == SHIFT) && !bus.stall;

    sff_chain_sreg #(
        .WIDTH (WIDTH)
    ) u_load_reg (
        .ck        (ck),
        .rst       (rst),
        .load      (accept),
        .load_data (bus.din),
        .shift     (advance),
        .ser_in    (1'b0),
        .q         (shreg)
    );

    sff_chain_sreg #(
        .WIDTH (WIDTH)
    ) u_cap_reg (
        .ck        (ck),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (advance),
        .ser_in    (bus.si),
        .q         (cap)
    );

    // Sequencer: count WIDTH advancing edges, spend one cycle in UPDATE,
    // and keep the captured word around until the next UPDATE replaces it.
    always_ff @(posedge ck) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dout_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.din_valid) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (!bus.stall) begin
                        if (cnt == LAST) begin
                            state <= UPDATE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                UPDATE: begin
                    dout_q <= cap;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The load register is all zeros outside SHIFT (reset value, or fully
    // shifted out), so its LSB can drive the chain directly.
    assign bus.so         = shreg[0];
    assign bus.sen        = advance;
    assign bus.upd        = (state == UPDATE);
    assign bus.dout_valid = (state == UPDATE);
    assign bus.dout       = (state == UPDATE) ? cap : dout_q;
    assign bus.din_ready  = (state == IDLE) && !rst;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_sff_chain_loader.sv
// Self-checking bench for sff_chain_loader with an 8-flop behavioural chain
// and a scoreboard of expected readback words.
module tb_sff_chain_loader;

    localparam int W = 8;

    logic ck;
    logic rst;

    sff_chain_loader_if #(.WIDTH(W)) bus ();

    sff_chain_loader #(
        .WIDTH (W)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.slave)
    );

    int assert_count = 0;
    int fail_count   = 0;
    int accepts      = 0;
    int upd_count    = 0;
    int aborts       = 0;

    logic [W-1:0] chain     = 8'h69;
    logic [W-1:0] last_word = '0;
    bit           use_chain = 1'b1;
    logic [W-1:0] sb_q[$];

    initial ck = 1'b0;

    // Free-running clock
    always #5 ck = ~ck;

    // Behavioural chain: head at bit 7, tail at bit 0
    assign bus.si = chain[0];

    // Chain advances on every edge where the loader asserts shift enable
    always @(posedge ck) begin
        if (bus.sen === 1'b1) chain <= {bus.so, chain[W-1:1]};
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected readback pushed at acceptance, popped at dout_valid
    always begin
        @(negedge ck);
        #2;
        if (rst) begin
            if (sb_q.size() != 0) aborts++;
            sb_q.delete();
            use_chain = 1'b1;
        end else begin
            if (bus.dout_valid) begin
                upd_count++;
                if (sb_q.size() == 0) check_output("sb_unexpected_dout_valid", bus.dout_valid, 0);
                else check_output("sb_dout", bus.dout, sb_q.pop_front());
                check_output("sb_upd_with_valid", bus.upd, 1);
            end else begin
                check_output("sb_upd_without_valid", bus.upd, 0);
            end
            if (bus.din_valid && bus.din_ready) begin
                accepts++;
                sb_q.push_back(use_chain ? chain : last_word);
                last_word = bus.din;
                use_chain = 1'b0;
            end
        end
    end

    // Offer a word until the loader takes it; returns in the accept cycle
    task automatic apply_stimulus(input logic [W-1:0] w);
        bit ok = 1'b0;
        for (int n = 0; n < 4 * W && !ok; n++) begin
            @(negedge ck);
            bus.din       = w;
            bus.din_valid = 1'b1;
            bus.stall     = 1'($urandom_range(0, 1));
            #1;
            ok = bus.din_ready;
        end
        check_output("accept_ready", ok, 1);
    endtask

    // Follow an accepted load through SHIFT to UPDATE; returns in UPDATE cycle
    task automatic finish_load(input logic [W-1:0] w, input int stall_after,
                               input int stall_len, input bit keep_valid);
        int shifts  = 0;
        int stalled = 0;
        int cyc     = 0;
        bit done    = 1'b0;
        bit stall_now;
        while (!done && cyc < 4 * W) begin
            @(negedge ck);
            stall_now     = (shifts == stall_after) && (stalled < stall_len);
            bus.stall     = stall_now;
            bus.din_valid = keep_valid;
            if (keep_valid) bus.din = W'($urandom);
            #1;
            cyc++;
            if (shifts < W) begin
                check_output("shift_sen", bus.sen, !stall_now);
                check_output("shift_so", bus.so, w[shifts]);
                check_output("shift_ready_low", bus.din_ready, 0);
                check_output("shift_busy", bus.busy, 1);
                check_output("shift_no_upd", bus.upd, 0);
                if (stall_now) stalled++;
                else shifts++;
            end else begin
                check_output("upd_pulse", bus.upd, 1);
                check_output("upd_dout_valid", bus.dout_valid, 1);
                check_output("upd_ready_low", bus.din_ready, 0);
                check_output("upd_chain", chain, w);
                check_output("upd_cycle", cyc, W + 1 + stall_len);
                done = 1'b1;
            end
        end
        bus.stall = 1'b0;
        check_output("load_timeout", done, 1);
    endtask

    // Hard stop if something hangs outside the bounded loops
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by randomised stress
    initial begin
        int acc0;
        int upd0;
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.stall     = 1'b0;

        repeat (2) @(negedge ck);
        #1;
        check_output("reset_ready_low", bus.din_ready, 0);
        @(negedge ck);
        rst = 1'b0;
        #1;
        check_output("reset_ready", bus.din_ready, 1);
        check_output("reset_sen", bus.sen, 0);
        check_output("reset_so", bus.so, 0);
        check_output("reset_upd", bus.upd, 0);
        check_output("reset_dout_valid", bus.dout_valid, 0);
        check_output("reset_dout", bus.dout, 0);
        check_output("reset_busy", bus.busy, 0);

        $display("[TB] single load 8'hA5");
        apply_stimulus(8'hA5);
        finish_load(8'hA5, 0, 0, 1'b0);
        check_output("t1_dout_old_chain", bus.dout, 8'h69);
        @(negedge ck);
        bus.din_valid = 1'b0;
        #1;
        check_output("t1_ready_again", bus.din_ready, 1);
        check_output("t1_busy_clear", bus.busy, 0);

        $display("[TB] readback 8'h3C then 8'hFF");
        apply_stimulus(8'h3C);
        finish_load(8'h3C, 0, 0, 1'b0);
        check_output("rb_first_dout", bus.dout, 8'hA5);
        apply_stimulus(8'hFF);
        finish_load(8'hFF, 0, 0, 1'b0);
        check_output("rb_second_dout", bus.dout, 8'h3C);
        check_output("rb_chain", chain, 8'hFF);
        repeat (3) begin
            @(negedge ck);
            bus.din_valid = 1'b0;
            #1;
            check_output("rb_dout_hold", bus.dout, 8'h3C);
        end

        $display("[TB] stall of 3 cycles after 4th shift of 8'h81");
        apply_stimulus(8'h81);
        finish_load(8'h81, 4, 3, 1'b0);
        check_output("stall_dout", bus.dout, 8'hFF);
        check_output("stall_chain", chain, 8'h81);

        $display("[TB] handshake with din_valid held high");
        apply_stimulus(8'hC3);
        finish_load(8'hC3, 0, 0, 1'b1);
        @(negedge ck);
        bus.din       = 8'h9E;
        bus.din_valid = 1'b1;
        #1;
        check_output("hs_ready_after_upd", bus.din_ready, 1);
        finish_load(8'h9E, 0, 0, 1'b0);
        check_output("hs_dout", bus.dout, 8'hC3);
        check_output("hs_chain", chain, 8'h9E);

        $display("[TB] reset during 5th shift");
        apply_stimulus(8'h5B);
        for (int k = 1; k <= 5; k++) begin
            @(negedge ck);
            bus.din_valid = 1'b0;
            bus.stall     = 1'b0;
            if (k == 5) rst = 1'b1;
            #1;
            if (k < 5) check_output("abort_sen_before", bus.sen, 1);
        end
        @(negedge ck);
        rst = 1'b0;
        #1;
        check_output("abort_ready", bus.din_ready, 1);
        check_output("abort_busy", bus.busy, 0);
        check_output("abort_sen", bus.sen, 0);
        check_output("abort_upd", bus.upd, 0);
        check_output("abort_dout_valid", bus.dout_valid, 0);
        repeat (10) begin
            @(negedge ck);
            #1;
            check_output("abort_no_dout_valid", bus.dout_valid, 0);
        end
        apply_stimulus(8'h12);
        finish_load(8'h12, 0, 0, 1'b0);
        @(negedge ck);
        bus.din_valid = 1'b0;
        #1;
        check_output("abort_reload_ready", bus.din_ready, 1);

        $display("[TB] stress: 100 random words with random stalls");
        acc0 = accepts;
        upd0 = upd_count;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge ck);
                    bus.din_valid = 1'b0;
                    bus.stall     = 1'($urandom_range(0, 1));
                end
            end
            apply_stimulus(w);
            finish_load(w, $urandom_range(0, W - 1), $urandom_range(0, 3), 1'b0);
        end
        @(negedge ck);
        bus.din_valid = 1'b0;
        bus.stall     = 1'b0;
        #3;
        check_output("stress_upd_count", upd_count - upd0, accepts - acc0);
        check_output("sb_drained", sb_q.size(), 0);
        check_output("total_upd_count", upd_count, accepts - aborts);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
